// File: rtl/argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : argmax_pkg
// Purpose  : Shared types and helpers for the streaming top-2 argmax block:
//            FSM state encoding, signed-range helper and index-width check.
// Revision : 1.0 - initial streaming top-2 release
// ============================================================================
package argmax_pkg;

  // Output handshake FSM: accumulate beats, then hold the result.
  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Most negative value representable in a two's-complement field of 'width'.
  function automatic longint min_signed(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

  // True when an index field of 'idx_width' bits can address 'num_class' classes.
  function automatic bit idx_fits(input int num_class, input int idx_width);
    return (longint'(1) << idx_width) >= longint'(num_class);
  endfunction

  // Default configuration and its width sanity check.
  localparam int c_DEF_NUM_CLASS  = 10;
  localparam int c_DEF_DATA_WIDTH = 29;
  localparam int c_DEF_IDX_WIDTH  = 8;
  localparam bit c_DEF_IDX_FITS   = idx_fits(c_DEF_NUM_CLASS, c_DEF_IDX_WIDTH);

endpackage : argmax_pkg
`default_nettype wire

// File: rtl/top2_update.sv
`default_nettype none
// ============================================================================
// Module   : top2_update
// Purpose  : Combinational best/second-best update for one new signed score.
//            Ties keep the earlier (lower) index because only strict
//            greater-than comparisons ever displace a held entry.
// Revision : 1.0 - initial streaming top-2 release
// ============================================================================
module top2_update
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 29,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                         first,
  input  logic [IDX_WIDTH-1:0]         idx,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic signed [DATA_WIDTH-1:0] cur_best,
  input  logic [IDX_WIDTH-1:0]         cur_best_idx,
  input  logic signed [DATA_WIDTH-1:0] cur_second,
  input  logic [IDX_WIDTH-1:0]         cur_second_idx,
  input  logic                         cur_second_valid,
  output logic signed [DATA_WIDTH-1:0] nxt_best,
  output logic [IDX_WIDTH-1:0]         nxt_best_idx,
  output logic signed [DATA_WIDTH-1:0] nxt_second,
  output logic [IDX_WIDTH-1:0]         nxt_second_idx,
  output logic                         nxt_second_valid
);

  // Select the next top-2 pair; the second slot mirrors best until a second beat arrives.
  always_comb begin
    nxt_best         = cur_best;
    nxt_best_idx     = cur_best_idx;
    nxt_second       = cur_second;
    nxt_second_idx   = cur_second_idx;
    nxt_second_valid = cur_second_valid;
    if (first) begin
      nxt_best         = data;
      nxt_best_idx     = idx;
      nxt_second       = data;
      nxt_second_idx   = idx;
      nxt_second_valid = 1'b0;
    end else if (data > cur_best) begin
      nxt_second       = cur_best;
      nxt_second_idx   = cur_best_idx;
      nxt_second_valid = 1'b1;
      nxt_best         = data;
      nxt_best_idx     = idx;
    end else if (!cur_second_valid || (data > cur_second)) begin
      nxt_second       = data;
      nxt_second_idx   = idx;
      nxt_second_valid = 1'b1;
    end
  end

endmodule : top2_update
`default_nettype wire

// File: rtl/argmax_top2_stream.sv
`default_nettype none
// ============================================================================
// Module   : argmax_top2_stream
// Purpose  : Streaming argmax over one signed class score per beat. Reports
//            predicted and runner-up class, best score, top-1/top-2 margin and
//            a frame-length error on a held valid/ready result interface.
// Revision : 1.0 - initial streaming top-2 release
// ============================================================================
module argmax_top2_stream
  import argmax_pkg::*;
#(
  parameter int NUM_CLASS  = 10,
  parameter int DATA_WIDTH = 29,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  predict,
  output logic [IDX_WIDTH-1:0]  second,
  output logic [DATA_WIDTH-1:0] max_score,
  output logic [DATA_WIDTH:0]   margin,
  output logic                  frame_err
);

  localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

  // Refuse to elaborate a configuration whose index field cannot hold every class.
  generate
    if (!idx_fits(NUM_CLASS, IDX_WIDTH) || (NUM_CLASS < 2)) begin : g_param_check
      $error("argmax_top2_stream: IDX_WIDTH too small or NUM_CLASS < 2");
    end
  endgenerate

  state_t                         r_state;
  state_t                         w_next_state;
  logic                           r_in_ready;
  logic                           r_out_valid;
  logic [IDX_WIDTH-1:0]           r_cnt;

  logic signed [DATA_WIDTH-1:0]   r_best;
  logic [IDX_WIDTH-1:0]           r_best_idx;
  logic signed [DATA_WIDTH-1:0]   r_second;
  logic [IDX_WIDTH-1:0]           r_second_idx;
  logic                           r_second_valid;

  logic signed [DATA_WIDTH-1:0]   w_nxt_best;
  logic [IDX_WIDTH-1:0]           w_nxt_best_idx;
  logic signed [DATA_WIDTH-1:0]   w_nxt_second;
  logic [IDX_WIDTH-1:0]           w_nxt_second_idx;
  logic                           w_nxt_second_valid;

  logic [IDX_WIDTH-1:0]           r_predict;
  logic [IDX_WIDTH-1:0]           r_second_out;
  logic [DATA_WIDTH-1:0]          r_max_score;
  logic [DATA_WIDTH:0]            r_margin;
  logic                           r_frame_err;

  logic                           w_accept;
  logic                           w_at_last;
  logic                           w_close;
  logic                           w_len_err;
  logic [DATA_WIDTH:0]            w_margin;

  // in_ready is only ever high in ACC, so a handshake implies the accumulate state.
  assign w_accept  = in_valid && r_in_ready;
  assign w_at_last = (r_cnt == c_LAST_IDX);
  assign w_close   = w_accept && (in_last || w_at_last);
  // Exactly one of the two closing conditions firing means the frame length was wrong.
  assign w_len_err = in_last ^ w_at_last;
  // Sign-extend both operands one bit so the difference never wraps; best >= second.
  assign w_margin  = {w_nxt_best[DATA_WIDTH-1], w_nxt_best}
                   - {w_nxt_second[DATA_WIDTH-1], w_nxt_second};

  top2_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_top2_update (
    .first            (r_cnt == '0),
    .idx              (r_cnt),
    .data             (in_data),
    .cur_best         (r_best),
    .cur_best_idx     (r_best_idx),
    .cur_second       (r_second),
    .cur_second_idx   (r_second_idx),
    .cur_second_valid (r_second_valid),
    .nxt_best         (w_nxt_best),
    .nxt_best_idx     (w_nxt_best_idx),
    .nxt_second       (w_nxt_second),
    .nxt_second_idx   (w_nxt_second_idx),
    .nxt_second_valid (w_nxt_second_valid)
  );

  // Next-state logic: close a frame into OUT, release back to ACC on out_ready.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACC:  if (w_close)   w_next_state = ST_OUT;
      ST_OUT:  if (out_ready) w_next_state = ST_ACC;
      default: w_next_state = ST_ACC;
    endcase
  end

  // State register with registered handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ACC;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == ST_ACC);
      r_out_valid <= (w_next_state == ST_OUT);
    end
  end

  // Beat counter: restarts at every frame close, otherwise saturates at the last class.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_close) begin
      r_cnt <= '0;
    end else if (w_accept && !w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Running top-2 state, updated on every accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best         <= '0;
      r_best_idx     <= '0;
      r_second       <= '0;
      r_second_idx   <= '0;
      r_second_valid <= 1'b0;
    end else if (w_accept) begin
      r_best         <= w_nxt_best;
      r_best_idx     <= w_nxt_best_idx;
      r_second       <= w_nxt_second;
      r_second_idx   <= w_nxt_second_idx;
      r_second_valid <= w_nxt_second_valid;
    end
  end

  // Result registers capture the post-update values of the closing beat and then hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_predict    <= '0;
      r_second_out <= '0;
      r_max_score  <= '0;
      r_margin     <= '0;
      r_frame_err  <= 1'b0;
    end else if (w_close) begin
      r_predict    <= w_nxt_best_idx;
      r_second_out <= w_nxt_second_idx;
      r_max_score  <= w_nxt_best;
      r_margin     <= w_margin;
      r_frame_err  <= w_len_err;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign predict   = r_predict;
  assign second    = r_second_out;
  assign max_score = r_max_score;
  assign margin    = r_margin;
  assign frame_err = r_frame_err;

endmodule : argmax_top2_stream
`default_nettype wire

// File: tb/tb_argmax_top2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_top2_stream
// Purpose  : Directed self-checking bench for argmax_top2_stream with
//            hand-computed expected results per frame.
// Revision : 1.0 - initial streaming top-2 release
// ============================================================================
module tb_argmax_top2_stream;

  localparam int c_NUM_CLASS  = 10;
  localparam int c_DATA_WIDTH = 29;
  localparam int c_IDX_WIDTH  = 8;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [c_DATA_WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [c_IDX_WIDTH-1:0]  predict;
  logic [c_IDX_WIDTH-1:0]  second;
  logic [c_DATA_WIDTH-1:0] max_score;
  logic [c_DATA_WIDTH:0]   margin;
  logic                    frame_err;

  int n_checks;
  int n_fail;
  int sv[10];

  argmax_top2_stream #(
    .NUM_CLASS  (c_NUM_CLASS),
    .DATA_WIDTH (c_DATA_WIDTH),
    .IDX_WIDTH  (c_IDX_WIDTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .predict   (predict),
    .second    (second),
    .max_score (max_score),
    .margin    (margin),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat after 'gap' idle cycles; returns at posedge+1 after acceptance.
  task automatic send_beat(input int d, input bit last, input int gap);
    bit acc;
    bit ok;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d[c_DATA_WIDTH-1:0];
    in_last  = last;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) check("beat_timeout", 64'd0, 64'd1);
  endtask

  // Stream sv[0..n-1]; in_last on beat last_at (-1: never).
  task automatic run_frame(input int n, input int last_at, input int max_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      send_beat(sv[i], (i == last_at), gap);
    end
  endtask

  // Called right after the closing beat is accepted: result must already be valid.
  task automatic check_result(input string tag, input int pr, input int sc,
                              input int mx, input int mg, input int er);
    logic [c_DATA_WIDTH-1:0] emx;
    emx = mx[c_DATA_WIDTH-1:0];
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_predict"},   64'(predict),   64'(pr));
    check({tag, "_second"},    64'(second),    64'(sc));
    check({tag, "_max_score"}, 64'(max_score), 64'(emx));
    check({tag, "_margin"},    64'(margin),    64'(mg));
    check({tag, "_frame_err"}, 64'(frame_err), 64'(er));
  endtask

  // Accept the held result and confirm return to accumulate.
  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_pop_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_pop_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_predict",   64'(predict),   64'd0);
    check("rst_margin",    64'(margin),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", 64'(in_ready), 64'd1);

    // Tie between beats 2 and 4: lower index wins, runner-up is the tie partner.
    sv = '{5, -3, 100, 7, 100, -1, 0, 2, 99, 4};
    run_frame(10, 9, 0);
    check_result("tie", 2, 4, 100, 0, 0);
    pop("tie");

    // All negative scores with a repeated maximum.
    sv = '{-50, -2, -9, -2, -100, -200, -300, -7, -8, -9};
    run_frame(10, 9, 0);
    check_result("neg", 1, 3, -2, 0, 0);
    pop("neg");

    // Extreme signed values: positive maximum beats the most negative score.
    sv = '{-268435456, 268435455, -1, -2, -3, -4, -5, -6, -7, -8};
    run_frame(10, 9, 0);
    check_result("ext", 1, 2, 268435455, 268435456, 0);
    pop("ext");

    // Early in_last on beat 3.
    sv = '{1, 4, 2, 3, 0, 0, 0, 0, 0, 0};
    run_frame(4, 3, 0);
    check_result("short", 1, 3, 4, 1, 1);
    pop("short");

    // Full length without in_last: closes on the last class, next frame from index 0.
    sv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_frame(10, -1, 0);
    check_result("nolast", 9, 8, 9, 1, 1);
    pop("nolast");

    // Single-beat frame.
    sv = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, 0, 0);
    check_result("single", 0, 0, 42, 0, 1);
    pop("single");

    // Held output: consumer stalls for 20 cycles.
    sv = '{5, -3, 100, 7, 100, -1, 0, 2, 99, 4};
    run_frame(10, 9, 0);
    check_result("stall", 2, 4, 100, 0, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_predict",   64'(predict),   64'd2);
      check("stall_margin",    64'(margin),    64'd0);
    end
    pop("stall");

    // Idle gaps between beats give the same answer.
    sv = '{-50, -2, -9, -2, -100, -200, -300, -7, -8, -9};
    run_frame(10, 9, 3);
    check_result("gaps", 1, 3, -2, 0, 0);
    pop("gaps");

    // Reset mid-frame after five beats discards the partial frame.
    sv = '{5, -3, 100, 7, 100, -1, 0, 2, 99, 4};
    run_frame(5, -1, 0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd0);
    check("midrst_predict",   64'(predict),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sv = '{-268435456, 268435455, -1, -2, -3, -4, -5, -6, -7, -8};
    run_frame(10, 9, 0);
    check_result("postrst", 1, 2, 268435455, 268435456, 0);
    pop("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_argmax_top2_stream
`default_nettype wire

// File: doc/argmax_top2_stream.md
Name: argmax_top2_stream

Overview:
- Parametrised successor to the NN output-layer argmax comparator.
- Consumes one class score per cycle on a valid/ready stream instead of a wide parallel bus.
- Tracks the best and second-best signed scores, then presents predicted class, runner-up class, max score, top-1/top-2 margin and a framing error on a held output handshake.
- Sits between the final dense/accumulate stage and the result/UART logic.

Parameters:
- NUM_CLASS, 10, number of scores per frame (>=2).
- DATA_WIDTH, 29, two's-complement score width.
- IDX_WIDTH, 8, width of class index outputs (2^IDX_WIDTH >= NUM_CLASS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_WIDTH  signed score of class (beat index).
- in_last  in  1  last beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- predict  out  IDX_WIDTH  argmax index.
- second  out  IDX_WIDTH  runner-up index.
- max_score  out  DATA_WIDTH  best score.
- margin  out  DATA_WIDTH+1  unsigned max_score - second score.
- frame_err  out  1  frame length mismatch flag.

Behaviour:
- Reset (rst low, async): state=ACC, beat counter=0, in_ready=0, out_valid=0, all result outputs 0. in_ready rises on the first clk edge after rst deasserts.
- Beat accepted when in_valid && in_ready. Index = beat counter value (0..NUM_CLASS-1).
- Signed compare throughout, full DATA_WIDTH. No unsigned compare on sign-mixed operands.
- Beat 0: best=data, best_idx=0. Second marked invalid.
- Later beats:
  - data > best (strict): second<=best, second_idx<=best_idx, best<=data, best_idx<=idx.
  - Else if second invalid or data > second (strict): second<=data, second_idx<=idx.
  - Ties keep the lower index.
- Frame close: accepted beat with in_last=1, or counter==NUM_CLASS-1, whichever comes first.
  - frame_err=1 if in_last arrives with counter!=NUM_CLASS-1, or counter reaches NUM_CLASS-1 without in_last.
  - The frame still closes. Extra beats belong to the next frame.
- FSM:
  - ACC: in_ready=1. Frame close -> OUT on the next edge.
  - OUT: in_ready=0, out_valid=1. All outputs stable until out_ready sampled high, then -> ACC with counter=0.
  - out_valid rises exactly 1 cycle after the closing beat. Minimum frame period is NUM_CLASS+1 cycles.
- Single-beat frame (in_last on beat 0): second=predict, margin=0, frame_err=1.
- margin = best - second, computed in DATA_WIDTH+1 bits. It is never negative.
- Counter saturates at NUM_CLASS-1. Reset mid-frame discards partial state.
- Outputs are registered, with no combinational path from in_* to out_*.

Decomposition:
- Package argmax_pkg: FSM state enum (ACC, OUT), function min_signed(width), localparam check that IDX_WIDTH fits NUM_CLASS.
- Sub-module top2_update (combinational): takes current best/second/indices/second_valid plus the new beat, returns the next values. Reused by later parallel-tree variants.

Test Plan:
- Scores 5,-3,100,7,100,-1,0,2,99,4 (NUM_CLASS=10, in_last on beat 9) -> predict=2, second=4, max_score=100, margin=0, frame_err=0. This is the tie-lower-index case.
- All scores negative: -50,-2,-9,-2,-100,... -> predict=1, second=3, margin=0. Also score 0x0FFFFFFF vs 0x10000000 (29-bit) -> positive max wins over negative.
- in_last on beat 3 of 10 with scores 1,4,2,3 -> out_valid one cycle later, predict=1, second=3, margin=1, frame_err=1. Next frame then starts at index 0.
- out_ready held low 20 cycles in OUT -> in_ready=0, outputs unchanged. out_ready=1 -> next cycle ACC, in_ready=1.
- in_valid gaps (random 0-3 idle cycles between beats) -> same result as back-to-back delivery.
- rst pulsed low mid-frame after 5 beats -> out_valid=0 immediately. The following full frame is evaluated from index 0 correctly.
